rf_command_controller: RTL

//  Upstream master of the register file. Consumes bytes from the UART receiver and parses

---
 rtl/rf_cmd_pkg.sv | 22 ++
 rtl/byte_timeout_timer.sv | 31 +++
 rtl/rf_command_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rf_cmd_pkg.sv
// Shared opcodes and FSM state encoding for the register-file command controller.
// Used by rf_command_controller (optional CMD_TIMEOUT_EN build adds byte_timeout_timer).
package rf_cmd_pkg;

  localparam logic [7:0] CMD_RF_WRITE = 8'hAA;
  localparam logic [7:0] CMD_RF_READ  = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_t;

  // States in which a partially received frame may be abandoned by the inter-byte timer.
  function automatic logic is_timed_state(input state_t s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR);
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte timeout: down-counter reloaded on clear or while disabled; expired is the
// terminal-count compare while enabled. Only instantiated when CMD_TIMEOUT_EN is defined.
module byte_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] LOAD_VALUE = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= LOAD_VALUE;
    end else if (clear || !enable) begin
      count <= LOAD_VALUE;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive enabled cycle with no clear.
  assign expired = enable && !clear && (count == '0);

endmodule

// File: rtl/rf_command_controller.sv
// Parses UART command frames (AA,addr,data = write; BB,addr = read) into register-file
// strobes and returns read data over tx_valid/tx_ready. Define CMD_TIMEOUT_EN for inter-byte timeout.
module rf_command_controller
  import rf_cmd_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int TIMEOUT_CYCLES      = 1024,
  localparam int ADDR_WIDTH         = $clog2(REGISTER_FILE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_data_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  cmd_error
);

  // state      | meaning
  // ST_IDLE    | waiting for an opcode byte
  // ST_WR_ADDR | write opcode seen, waiting for address byte
  // ST_WR_DATA | address latched, waiting for data byte
  // ST_RD_ADDR | read opcode seen, waiting for address byte
  // ST_RD_WAIT | read strobe issued, waiting for read_data_valid
  // ST_TX_SEND | response held on tx_data until tx_ready

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("rf_command_controller: TIMEOUT_CYCLES must be at least 2");
  end

  state_t state;
  logic   addr_ok;
  logic   is_write_op;
  logic   is_read_op;
  logic   timeout_expired;

  assign addr_ok     = (rx_data[DATA_WIDTH-1:ADDR_WIDTH] == '0);
  assign is_write_op = (rx_data == DATA_WIDTH'(CMD_RF_WRITE));
  assign is_read_op  = (rx_data == DATA_WIDTH'(CMD_RF_READ));

`ifdef CMD_TIMEOUT_EN
  logic timer_clear;

  assign timer_clear = rx_valid || !is_timed_state(state);

  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (is_timed_state(state)),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      address      <= '0;
      write_enable <= 1'b0;
      write_data   <= '0;
      read_enable  <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      cmd_error    <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      cmd_error    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (is_write_op) begin
              state <= ST_WR_ADDR;
            end else if (is_read_op) begin
              state <= ST_RD_ADDR;
            end else begin
              cmd_error <= 1'b1;
            end
          end
        end

        ST_WR_ADDR: begin
          if (rx_valid) begin
            if (addr_ok) begin
              address <= rx_data[ADDR_WIDTH-1:0];
              state   <= ST_WR_DATA;
            end else begin
              cmd_error <= 1'b1;
              state     <= ST_IDLE;
            end
          end else if (timeout_expired) begin
            cmd_error <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        ST_WR_DATA: begin
          if (rx_valid) begin
            write_data   <= rx_data;
            write_enable <= 1'b1;
            state        <= ST_IDLE;
          end else if (timeout_expired) begin
            cmd_error <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        ST_RD_ADDR: begin
          if (rx_valid) begin
            if (addr_ok) begin
              address     <= rx_data[ADDR_WIDTH-1:0];
              read_enable <= 1'b1;
              state       <= ST_RD_WAIT;
            end else begin
              cmd_error <= 1'b1;
              state     <= ST_IDLE;
            end
          end else if (timeout_expired) begin
            cmd_error <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        // Bytes arriving while a response is outstanding are overruns and are dropped.
        ST_RD_WAIT: begin
          if (rx_valid) begin
            cmd_error <= 1'b1;
          end
          if (read_data_valid) begin
            tx_data  <= read_data;
            tx_valid <= 1'b1;
            state    <= ST_TX_SEND;
          end
        end

        ST_TX_SEND: begin
          if (rx_valid) begin
            cmd_error <= 1'b1;
          end
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        default: begin
          tx_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
